// File: rtl/axis_lane_weight_multiplier.sv
// Per-lane signed AXI-Stream multiplier: 2-stage pipeline with frame-aligned weight updates from a shadow set.
// Define AXIS_MULT_ROUND_SAT_EN to round and saturate each lane result back to sample range.
module axis_lane_weight_multiplier #(
    parameter int NUM_LANES    = 16,
    parameter int SAMPLE_WIDTH = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUT_SHIFT    = 7,
    parameter int PROD_WIDTH   = SAMPLE_WIDTH + WEIGHT_WIDTH
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [NUM_LANES*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_LANES-1:0]             s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic [NUM_LANES*WEIGHT_WIDTH-1:0] weight_data,
    input  logic                             weight_load,
    output logic                             weight_pending,
    output logic [NUM_LANES*PROD_WIDTH-1:0]  m_axis_s2mm_tdata,
    output logic [NUM_LANES-1:0]             m_axis_s2mm_tkeep,
    output logic                             m_axis_s2mm_tlast,
    output logic                             m_axis_s2mm_tvalid,
    input  logic                             m_axis_s2mm_tready
);
    localparam int SW = NUM_LANES * SAMPLE_WIDTH;
    localparam int WW = NUM_LANES * WEIGHT_WIDTH;
    localparam int PW = NUM_LANES * PROD_WIDTH;

    if (OUT_SHIFT < 1) begin : g_bad_shift
        $error("OUT_SHIFT must be at least 1");
    end

    logic                 v1_q, v1_d;
    logic [SW-1:0]        samp1_q, samp1_d;
    logic [NUM_LANES-1:0] keep1_q, keep1_d;
    logic                 last1_q, last1_d;
    logic [WW-1:0]        wt1_q, wt1_d;
    logic                 v2_q, v2_d;
    logic [PW-1:0]        data2_q, data2_d;
    logic [NUM_LANES-1:0] keep2_q, keep2_d;
    logic                 last2_q, last2_d;
    logic [WW-1:0]        active_q, active_d;
    logic [WW-1:0]        shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 in_frame_q, in_frame_d;
    logic [PW-1:0]        lane_res;
    logic                 load1, load2, accept, apply;

    // Lane arithmetic sits between S1 and S2, so rounding adds no latency.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic signed [SAMPLE_WIDTH-1:0] samp;
        logic signed [WEIGHT_WIDTH-1:0] wt;
        logic signed [PROD_WIDTH-1:0]   prod;
        logic signed [PROD_WIDTH-1:0]   lane;

        assign samp = samp1_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign wt   = wt1_q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign prod = PROD_WIDTH'(samp) * PROD_WIDTH'(wt);
`ifdef AXIS_MULT_ROUND_SAT_EN
        localparam logic signed [PROD_WIDTH:0] RND    = (PROD_WIDTH+1)'(1) << (OUT_SHIFT-1);
        localparam logic signed [PROD_WIDTH:0] SAT_HI = (PROD_WIDTH+1)'((1 << (SAMPLE_WIDTH-1)) - 1);
        localparam logic signed [PROD_WIDTH:0] SAT_LO = ~SAT_HI;
        logic signed [PROD_WIDTH:0] sum;
        logic signed [PROD_WIDTH:0] shr;

        assign sum  = $signed({prod[PROD_WIDTH-1], prod}) + RND;
        assign shr  = sum >>> OUT_SHIFT;
        assign lane = (shr > SAT_HI) ? SAT_HI[PROD_WIDTH-1:0] :
                      (shr < SAT_LO) ? SAT_LO[PROD_WIDTH-1:0] : shr[PROD_WIDTH-1:0];
`else
        assign lane = prod;
`endif
        assign lane_res[k*PROD_WIDTH +: PROD_WIDTH] = keep1_q[k] ? lane : '0;
    end

    always_comb begin
        load2      = !v2_q || m_axis_s2mm_tready;
        load1      = !v1_q || load2;
        accept     = s_axis_tvalid && load1;
        apply      = accept && !in_frame_q && pending_q;

        v1_d       = v1_q;
        samp1_d    = samp1_q;
        keep1_d    = keep1_q;
        last1_d    = last1_q;
        wt1_d      = wt1_q;
        v2_d       = v2_q;
        data2_d    = data2_q;
        keep2_d    = keep2_q;
        last2_d    = last2_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        in_frame_d = in_frame_q;

        if (load2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = lane_res;
                keep2_d = keep1_q;
                last2_d = last1_q;
            end
        end
        if (load1) begin
            v1_d = accept;
        end
        if (accept) begin
            samp1_d    = s_axis_tdata;
            keep1_d    = s_axis_tkeep;
            last1_d    = s_axis_tlast;
            wt1_d      = apply ? shadow_q : active_q;
            in_frame_d = !s_axis_tlast;
        end
        // A load coinciding with an apply still leaves the fresh value pending.
        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (weight_load) begin
            shadow_d  = weight_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            v1_q       <= 1'b0;
            samp1_q    <= '0;
            keep1_q    <= '0;
            last1_q    <= 1'b0;
            wt1_q      <= '0;
            v2_q       <= 1'b0;
            data2_q    <= '0;
            keep2_q    <= '0;
            last2_q    <= 1'b0;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            samp1_q    <= samp1_d;
            keep1_q    <= keep1_d;
            last1_q    <= last1_d;
            wt1_q      <= wt1_d;
            v2_q       <= v2_d;
            data2_q    <= data2_d;
            keep2_q    <= keep2_d;
            last2_q    <= last2_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign s_axis_tready      = load1;
    assign weight_pending     = pending_q;
    assign m_axis_s2mm_tdata  = data2_q;
    assign m_axis_s2mm_tkeep  = keep2_q;
    assign m_axis_s2mm_tlast  = last2_q;
    assign m_axis_s2mm_tvalid = v2_q;

endmodule

// File: tb/tb_axis_lane_weight_multiplier.sv
// Randomized bench for axis_lane_weight_multiplier against a queue-based behavioural model,
// plus literal expectations for known products (both with and without AXIS_MULT_ROUND_SAT_EN).
module tb_axis_lane_weight_multiplier;
    localparam int NL  = 16;
    localparam int SW  = 8;
    localparam int WW  = 8;
    localparam int SH  = 7;
    localparam int PWD = SW + WW;
    localparam int TD  = NL * SW;
    localparam int WD  = NL * WW;
    localparam int PD  = NL * PWD;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [TD-1:0] s_axis_tdata = '0;
    logic [NL-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic [WD-1:0] weight_data = '0;
    logic          weight_load = 1'b0;
    logic          weight_pending;
    logic [PD-1:0] m_axis_s2mm_tdata;
    logic [NL-1:0] m_axis_s2mm_tkeep;
    logic          m_axis_s2mm_tlast;
    logic          m_axis_s2mm_tvalid;
    logic          m_axis_s2mm_tready = 1'b1;

    always #5 CLK = ~CLK;

    axis_lane_weight_multiplier dut (
        .CLK                (CLK),
        .reset              (reset),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tlast       (s_axis_tlast),
        .weight_data        (weight_data),
        .weight_load        (weight_load),
        .weight_pending     (weight_pending),
        .m_axis_s2mm_tdata  (m_axis_s2mm_tdata),
        .m_axis_s2mm_tkeep  (m_axis_s2mm_tkeep),
        .m_axis_s2mm_tlast  (m_axis_s2mm_tlast),
        .m_axis_s2mm_tvalid (m_axis_s2mm_tvalid),
        .m_axis_s2mm_tready (m_axis_s2mm_tready)
    );

    int n_vec = 0;
    int n_err = 0;
    int rmode = 0;

    typedef struct {
        logic [PD-1:0] data;
        logic [NL-1:0] keep;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    m_act[NL];
    int    m_sh[NL];
    bit    m_pend = 1'b0;
    bit    m_inframe = 1'b0;
    int    occ = 0;

    task automatic chk(input string name, input logic [PD-1:0] act, input logic [PD-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PD-1:0] model_beat(input logic [TD-1:0] d, input logic [NL-1:0] k,
                                                 input int w[NL]);
        logic [PD-1:0] res;
        res = '0;
        for (int l = 0; l < NL; l++) begin
            int s;
            int p;
            s = $signed(d[l*SW +: SW]);
            p = s * w[l];
`ifdef AXIS_MULT_ROUND_SAT_EN
            p = (p + (1 << (SH-1))) >>> SH;
            if (p > (1 << (SW-1)) - 1) p = (1 << (SW-1)) - 1;
            else if (p < -(1 << (SW-1))) p = -(1 << (SW-1));
`endif
            if (k[l]) res[l*PWD +: PWD] = PWD'(p);
        end
        return res;
    endfunction

    // Reference model and per-cycle checker; looks at the handshakes that the next rising edge will commit.
    initial begin
        bit    hold;
        beat_t prev;
        beat_t e;
        int    w[NL];
        bit    acc;
        bit    pop;
        hold = 0;
        for (int l = 0; l < NL; l++) begin
            m_act[l] = 0;
            m_sh[l]  = 0;
        end
        forever begin
            @(negedge CLK);
            #2;
            acc = s_axis_tvalid && s_axis_tready;
            pop = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
            if (reset) begin
                exp_q.delete();
                occ = 0;
                m_pend = 0;
                m_inframe = 0;
                hold = 0;
                for (int l = 0; l < NL; l++) begin
                    m_act[l] = 0;
                    m_sh[l]  = 0;
                end
            end else begin
                chk("s_tready", PD'(s_axis_tready), PD'((occ < 2) || m_axis_s2mm_tready));
                chk("pending", PD'(weight_pending), PD'(m_pend));
                if (hold) begin
                    chk("stall_valid", PD'(m_axis_s2mm_tvalid), PD'(1));
                    chk("stall_data", m_axis_s2mm_tdata, prev.data);
                    chk("stall_keep", PD'(m_axis_s2mm_tkeep), PD'(prev.keep));
                    chk("stall_last", PD'(m_axis_s2mm_tlast), PD'(prev.last));
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL stray_beat: got data %h expected no beat", m_axis_s2mm_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_axis_s2mm_tdata, e.data);
                        chk("out_keep", PD'(m_axis_s2mm_tkeep), PD'(e.keep));
                        chk("out_last", PD'(m_axis_s2mm_tlast), PD'(e.last));
                    end
                end
                if (acc) begin
                    if (!m_inframe && m_pend) begin
                        m_act = m_sh;
                        m_pend = 0;
                    end
                    w = m_act;
                    e.data = model_beat(s_axis_tdata, s_axis_tkeep, w);
                    e.keep = s_axis_tkeep;
                    e.last = s_axis_tlast;
                    exp_q.push_back(e);
                    m_inframe = !s_axis_tlast;
                end
                if (weight_load) begin
                    for (int l = 0; l < NL; l++) m_sh[l] = $signed(weight_data[l*WW +: WW]);
                    m_pend = 1;
                end
                occ = occ + int'(acc) - int'(pop);
                hold = m_axis_s2mm_tvalid && !m_axis_s2mm_tready;
                prev.data = m_axis_s2mm_tdata;
                prev.keep = m_axis_s2mm_tkeep;
                prev.last = m_axis_s2mm_tlast;
            end
        end
    end

    // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random, 3 always low.
    initial begin
        int c = 0;
        forever begin
            @(negedge CLK);
            case (rmode)
                0: m_axis_s2mm_tready = 1'b1;
                1: m_axis_s2mm_tready = (c % 4 == 0) || (c % 4 == 3);
                2: m_axis_s2mm_tready = 1'($urandom_range(0, 1));
                default: m_axis_s2mm_tready = 1'b0;
            endcase
            c++;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic load_w(input logic [WD-1:0] wd);
        weight_data = wd;
        weight_load = 1'b1;
        tick();
        weight_load = 1'b0;
    endtask

    task automatic send(input logic [TD-1:0] d, input logic [NL-1:0] k, input logic l,
                        input bit ld, input logic [WD-1:0] wd);
        bit done;
        int budget;
        done = 0;
        budget = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        if (ld) begin
            weight_data = wd;
            weight_load = 1'b1;
        end
        while (!done) begin
            #1;
            done = s_axis_tready;
            tick();
            weight_load = 1'b0;
            budget++;
            if (!done && budget > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: got no accept in %0d cycles, required accept", budget);
                done = 1;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    function automatic logic [WD-1:0] all_w(input logic [WW-1:0] v);
        logic [WD-1:0] r;
        for (int l = 0; l < NL; l++) r[l*WW +: WW] = v;
        return r;
    endfunction

    function automatic logic [TD-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [TD-1:0] d;
        logic [WD-1:0] wd;
        logic [NL-1:0] k;
        int            budget;

        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_s_tready", PD'(s_axis_tready), PD'(1));
        chk("rst_m_tvalid", PD'(m_axis_s2mm_tvalid), PD'(0));
        chk("rst_m_tdata", m_axis_s2mm_tdata, PD'(0));
        chk("rst_m_tkeep", PD'(m_axis_s2mm_tkeep), PD'(0));
        chk("rst_m_tlast", PD'(m_axis_s2mm_tlast), PD'(0));
        chk("rst_pending", PD'(weight_pending), PD'(0));
        tick();

        // weights 5, lane0=-3, lane1=7, single-beat frame
        load_w(all_w(8'd5));
        d = '0;
        d[7:0]  = 8'hFD;
        d[15:8] = 8'd7;
        send(d, '1, 1'b1, 0, '0);
        #1;
        chk("t1_lat_valid0", PD'(m_axis_s2mm_tvalid), PD'(0));
        tick();
        #1;
        chk("t1_lat_valid1", PD'(m_axis_s2mm_tvalid), PD'(1));
`ifdef AXIS_MULT_ROUND_SAT_EN
        chk("t1_lane0", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h0000));
        chk("t1_lane1", PD'(m_axis_s2mm_tdata[31:16]), PD'(16'h0000));
`else
        chk("t1_lane0", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'hFFF1));
        chk("t1_lane1", PD'(m_axis_s2mm_tdata[31:16]), PD'(16'h0023));
`endif
        chk("t1_tlast", PD'(m_axis_s2mm_tlast), PD'(1));
        chk("t1_tkeep", PD'(m_axis_s2mm_tkeep), PD'(16'hFFFF));
        tick();

        // extremes: 127*127, -128*-128, -128*127, 1*64
        wd = '0;
        wd[7:0] = 8'h7F; wd[15:8] = 8'h80; wd[23:16] = 8'h7F; wd[31:24] = 8'h40;
        load_w(wd);
        d = '0;
        d[7:0] = 8'h7F; d[15:8] = 8'h80; d[23:16] = 8'h80; d[31:24] = 8'h01;
        send(d, '1, 1'b1, 0, '0);
        tick();
        #1;
`ifdef AXIS_MULT_ROUND_SAT_EN
        chk("sat_127x127", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h007E));
        chk("sat_m128xm128", PD'(m_axis_s2mm_tdata[31:16]), PD'(16'h007F));
        chk("sat_m128x127", PD'(m_axis_s2mm_tdata[47:32]), PD'(16'hFF81));
        chk("sat_1x64", PD'(m_axis_s2mm_tdata[63:48]), PD'(16'h0001));
`else
        chk("sat_127x127", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h3F01));
        chk("sat_m128xm128", PD'(m_axis_s2mm_tdata[31:16]), PD'(16'h4000));
        chk("sat_m128x127", PD'(m_axis_s2mm_tdata[47:32]), PD'(16'hC080));
        chk("sat_1x64", PD'(m_axis_s2mm_tdata[63:48]), PD'(16'h0040));
`endif
        tick();

        // 8-beat frame with a weight load landing mid-frame
        for (int b = 0; b < 8; b++) send(rnd_data(), '1, b == 7, b == 3, all_w(8'd2));
        repeat (3) tick();
        #1;
        chk("t2_pend_after_frame", PD'(weight_pending), PD'(1));
        tick();
        d = '0;
        d[7:0] = 8'd100;
        send(d, '1, 1'b0, 0, '0);
        #1;
        chk("t2_pend_cleared", PD'(weight_pending), PD'(0));
        tick();
        #1;
`ifdef AXIS_MULT_ROUND_SAT_EN
        chk("t2_new_weight", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h0002));
`else
        chk("t2_new_weight", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h00C8));
`endif
        send(rnd_data(), '1, 1'b1, 0, '0);
        repeat (3) tick();

        // half-keep beat: samples 10, weights 3
        load_w(all_w(8'd3));
        d = '0;
        for (int l = 0; l < NL; l++) d[l*SW +: SW] = 8'd10;
        send(d, 16'h00FF, 1'b1, 0, '0);
        tick();
        #1;
`ifdef AXIS_MULT_ROUND_SAT_EN
        chk("t4_lane0", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h0000));
        chk("t4_lane7", PD'(m_axis_s2mm_tdata[127:112]), PD'(16'h0000));
`else
        chk("t4_lane0", PD'(m_axis_s2mm_tdata[15:0]), PD'(16'h001E));
        chk("t4_lane7", PD'(m_axis_s2mm_tdata[127:112]), PD'(16'h001E));
`endif
        chk("t4_lane8", PD'(m_axis_s2mm_tdata[143:128]), PD'(16'h0000));
        chk("t4_lane15", PD'(m_axis_s2mm_tdata[255:240]), PD'(16'h0000));
        chk("t4_tkeep", PD'(m_axis_s2mm_tkeep), PD'(16'h00FF));
        tick();

        // 32 continuous beats against a 1,0,0,1 ready pattern
        rmode = 1;
        for (int b = 0; b < 32; b++) send(rnd_data(), '1, b == 31, 0, '0);
        rmode = 0;
        repeat (6) tick();

        // reset with two beats in flight
        rmode = 3;
        load_w(all_w(8'd9));
        send(rnd_data(), '1, 1'b0, 0, '0);
        send(rnd_data(), '1, 1'b0, 0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_m_tvalid", PD'(m_axis_s2mm_tvalid), PD'(0));
        chk("t5_pending", PD'(weight_pending), PD'(0));
        rmode = 0;
        repeat (4) tick();
        d = '0;
        for (int l = 0; l < NL; l++) d[l*SW +: SW] = 8'd5;
        send(d, '1, 1'b1, 0, '0);
        tick();
        #1;
        chk("t5_zero_weights", m_axis_s2mm_tdata, PD'(0));
        tick();

        // randomized traffic with random backpressure and weight loads
        rmode = 2;
        for (int b = 0; b < 400; b++) begin
            case ($urandom_range(0, 3))
                0: k = '1;
                1: k = '0;
                default: k = NL'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) load_w({$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send(rnd_data(), k, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 {$urandom, $urandom, $urandom, $urandom});
        end

        rmode = 0;
        budget = 0;
        while ((exp_q.size() != 0 || occ != 0) && budget < 100) begin
            tick();
            budget++;
        end
        chk("drain_empty", PD'(exp_q.size()), PD'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
